// File: rtl/param_ff_bank.sv
// param_ff_bank: WIDTH clocked storage bits with run-time D/T/JK/SR mode,
// sticky per-bit forbidden-SR flags and a saturating transition counter.
module param_ff_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] sr_invalid,
  output logic [CNT_W-1:0] trans_cnt
);

  // Six bits hold any popcount of up to 32 bits.
  localparam int PC_W  = 6;
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] flags_r;
  logic [CNT_W-1:0] cnt_r;

  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] set_flags_s;
  logic [WIDTH-1:0] next_flags_s;
  logic [PC_W-1:0]  n_trans_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [SUM_W-1:0] cnt_sum_s;
  logic [CNT_W-1:0] next_cnt_s;

  // Number of set bits in a WIDTH-bit vector.
  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(PC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Per-bit next state; with en low, or on a forbidden SR pair, the bit holds.
  always_comb begin
    next_q_s = q_r;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (mode)
          MODE_D:  next_q_s[i] = a[i];
          MODE_T:  next_q_s[i] = q_r[i] ^ a[i];
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b01:   next_q_s[i] = 1'b0;
              2'b10:   next_q_s[i] = 1'b1;
              2'b11:   next_q_s[i] = ~q_r[i];
              default: next_q_s[i] = q_r[i];
            endcase
          end
          MODE_SR: begin
            case ({a[i], b[i]})
              2'b01:   next_q_s[i] = 1'b0;
              2'b10:   next_q_s[i] = 1'b1;
              default: next_q_s[i] = q_r[i];
            endcase
          end
          default: next_q_s[i] = q_r[i];
        endcase
      end
    end else begin
      next_q_s = q_r;
    end
  end

  // Forbidden-SR detection; a fresh set beats a simultaneous clear.
  always_comb begin
    set_flags_s = {WIDTH{1'b0}};
    if (en && (mode == MODE_SR)) begin
      set_flags_s = a & b;
    end else begin
      set_flags_s = {WIDTH{1'b0}};
    end
    if (clr_flags) begin
      next_flags_s = set_flags_s;
    end else begin
      next_flags_s = flags_r | set_flags_s;
    end
  end

  // Saturating transition count; a clear restarts from this edge's transitions.
  always_comb begin
    n_trans_s  = popcount(next_q_s ^ q_r);
    cnt_base_s = clr_flags ? {CNT_W{1'b0}} : cnt_r;
    cnt_sum_s  = {{PC_W{1'b0}}, cnt_base_s} + {{CNT_W{1'b0}}, n_trans_s};
    if (cnt_sum_s > {{PC_W{1'b0}}, CNT_MAX}) begin
      next_cnt_s = CNT_MAX;
    end else begin
      next_cnt_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // State registers; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r     <= RESET_VAL;
      flags_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      q_r     <= next_q_s;
      flags_r <= next_flags_s;
      cnt_r   <= next_cnt_s;
    end
  end

  assign Q          = q_r;
  assign Qn         = ~q_r;
  assign sr_invalid = flags_r;
  assign trans_cnt  = cnt_r;

endmodule

// File: tb/tb_param_ff_bank.sv
// Directed, table-driven bench for param_ff_bank. Two instances share the
// stimulus: one with an 8-bit counter and one with a 2-bit counter to
// exercise saturation.
module tb_param_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] a;
  logic [3:0] b;
  logic       clr_flags;

  logic [3:0] q8, qn8, f8;
  logic [7:0] c8;
  logic [3:0] q2, qn2, f2;
  logic [1:0] c2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_flags(clr_flags), .Q(q8), .Qn(qn8), .sr_invalid(f8), .trans_cnt(c8)
  );

  param_ff_bank #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b),
    .clr_flags(clr_flags), .Q(q2), .Qn(qn2), .sr_invalid(f2), .trans_cnt(c2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       clr;
    logic [3:0] exp_q;
    logic [3:0] exp_f;
    logic [7:0] exp_c8;
    logic [1:0] exp_c2;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [3:0] va, input logic [3:0] vb, input logic c);
    rst = r; en = e; mode = m; a = va; b = vb; clr_flags = c;
  endtask

  initial begin
    //            rst   en    mode   a        b        clr   Q        flags    c8      c2
    vecs[0]  = '{1'b1, 1'b1, 2'b11, 4'b1111, 4'b0101, 1'b1, 4'b1010, 4'b0000, 8'd0,  2'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'b01, 4'b0011, 4'b1100, 1'b0, 4'b1010, 4'b0000, 8'd0,  2'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'b00, 4'b0110, 4'b0000, 1'b0, 4'b0110, 4'b0000, 8'd2,  2'd2};
    vecs[3]  = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b1001, 4'b0000, 8'd6,  2'd3};
    vecs[4]  = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b0110, 4'b0000, 8'd10, 2'd3};
    vecs[5]  = '{1'b0, 1'b1, 2'b01, 4'b0001, 4'b1111, 1'b0, 4'b0111, 4'b0000, 8'd11, 2'd3};
    vecs[6]  = '{1'b0, 1'b1, 2'b00, 4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 8'd3,  2'd3};
    vecs[7]  = '{1'b0, 1'b1, 2'b10, 4'b1100, 4'b1010, 1'b0, 4'b1100, 4'b0000, 8'd5,  2'd3};
    vecs[8]  = '{1'b0, 1'b1, 2'b10, 4'b0101, 4'b1001, 1'b0, 4'b0101, 4'b0000, 8'd7,  2'd3};
    vecs[9]  = '{1'b0, 1'b1, 2'b11, 4'b1111, 4'b1111, 1'b0, 4'b0101, 4'b1111, 8'd7,  2'd3};
    vecs[10] = '{1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000, 1'b0, 4'b0101, 4'b1111, 8'd7,  2'd3};
    vecs[11] = '{1'b0, 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b1, 4'b0101, 4'b0000, 8'd0,  2'd0};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0, 4'b0101, 4'b0000, 8'd0,  2'd0};
    vecs[13] = '{1'b0, 1'b1, 2'b11, 4'b0011, 4'b0001, 1'b1, 4'b0111, 4'b0001, 8'd1,  2'd1};
    vecs[14] = '{1'b0, 1'b1, 2'b11, 4'b0000, 4'b0100, 1'b0, 4'b0011, 4'b0001, 8'd2,  2'd2};
    vecs[15] = '{1'b0, 1'b0, 2'b11, 4'b1111, 4'b1111, 1'b0, 4'b0011, 4'b0001, 8'd2,  2'd2};
    vecs[16] = '{1'b0, 1'b1, 2'b11, 4'b1000, 4'b0000, 1'b0, 4'b1011, 4'b0001, 8'd3,  2'd3};
    vecs[17] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0001, 8'd7,  2'd3};
    vecs[18] = '{1'b1, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b1010, 4'b0000, 8'd0,  2'd0};
    vecs[19] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0, 4'b0101, 4'b0000, 8'd4,  2'd3};

    drive(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].clr);
      @(posedge clk);
      #1;
      check("q",      i, {28'd0, q8},  {28'd0, vecs[i].exp_q});
      check("qn",     i, {28'd0, qn8}, {28'd0, ~vecs[i].exp_q});
      check("flags",  i, {28'd0, f8},  {28'd0, vecs[i].exp_f});
      check("cnt8",   i, {24'd0, c8},  {24'd0, vecs[i].exp_c8});
      check("q_sat",  i, {28'd0, q2},  {28'd0, vecs[i].exp_q});
      check("qn_sat", i, {28'd0, qn2}, {28'd0, ~vecs[i].exp_q});
      check("f_sat",  i, {28'd0, f2},  {28'd0, vecs[i].exp_f});
      check("cnt2",   i, {30'd0, c2},  {30'd0, vecs[i].exp_c2});
    end

    // 8-bit saturation: clear with no transitions (Q=0101, D a=0101), then
    // toggle all four bits every edge; 4*k climbs to 252 then pins at 255.
    drive(1'b0, 1'b1, 2'b00, 4'b0101, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("cnt8_clr", 100, {24'd0, c8}, 32'd0);
    check("cnt2_clr", 100, {30'd0, c2}, 32'd0);
    for (int k = 1; k <= 66; k++) begin
      drive(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000, 1'b0);
      @(posedge clk);
      #1;
      if (k == 1 || k == 63 || k == 64 || k == 66) begin
        check("cnt8_sat", 100 + k, {24'd0, c8}, (4 * k > 255) ? 32'd255 : 4 * k);
        check("cnt2_sat", 100 + k, {30'd0, c2}, 32'd3);
        check("q_tog",    100 + k, {28'd0, q8}, (k % 2 == 1) ? 32'h0000000A : 32'h00000005);
      end
    end

    // Reset after saturation clears everything at that edge.
    drive(1'b1, 1'b1, 2'b11, 4'b1111, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    check("rst_q",   200, {28'd0, q8}, 32'h0000000A);
    check("rst_f",   200, {28'd0, f8}, 32'd0);
    check("rst_cnt", 200, {24'd0, c8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
